io_bus_arbiter: RTL
===================

// Module: io_bus_arbiter
// PURPOSE
//  Two-requester arbiter sharing the single IO memory-mapped port (SPART/DVI/tick registers at 28'h8000000-8000006).
//  Requester 0 = CPU D-cache IO port; requester 1 = debug/boot-loader master.
//  Round-robin grant, one transaction at a time, bounded by a watchdog so a dead target cannot hang the CPU.
// PARAMETERS
//  ADDR_W        28            address width
//  DATA_W        32            data width
//  TIMEOUT_CYC   1024          max BUSY cycles waiting for m_ready before forced completion (>=2)
//  TIMEOUT_DATA  32'hDEADBEEF  read data returned on timeout
// PORTS
//  clk           in   1       clock
//  rst           in   1       synchronous, active-high reset
//  sN_valid      in   1       request N (N=0,1); held until sN_ready seen
//  sN_rw         in   1       1=write, 0=read
//  sN_addr       in   ADDR_W  address, stable while sN_valid
//  sN_data_wr    in   DATA_W  write data, stable while sN_valid
//  sN_data_rd    out  DATA_W  read data, valid only while sN_ready=1, else 0
//  sN_ready      out  1       one-cycle completion pulse
//  m_valid       out  1       to IO port
//  m_rw          out  1       granted rw (0 when idle)
//  m_addr        out  ADDR_W  granted addr (0 when idle)
//  m_data_wr     out  DATA_W  granted write data (0 when idle)
//  m_data_rd     in   DATA_W  from IO port
//  m_ready       in   1       from IO port
//  grant_id      out  1       current/last granted requester
//  timeout_err   out  1       one-cycle pulse on forced completion
//  err_addr      out  ADDR_W  address of last timed-out transaction (sticky until next timeout/reset)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; rr pointer favours s0; watchdog 0.
//  States: IDLE -> BUSY -> DRAIN -> IDLE.
//  IDLE: if any sN_valid, grant chosen at clock edge, enter BUSY; m_valid=0 in IDLE.
//   Both valid: grant the one NOT granted last (round robin); first after reset -> s0.
//  BUSY: m_valid=1; m_rw/m_addr/m_data_wr muxed combinationally from granted requester.
//   m_ready=1 sampled -> capture m_data_rd, enter DRAIN.
//   watchdog counts each BUSY cycle; reaching TIMEOUT_CYC-1 without m_ready -> capture TIMEOUT_DATA,
//   pulse timeout_err, latch err_addr, enter DRAIN with m_valid forced 0 in that DRAIN cycle.
//  DRAIN (exactly 1 cycle): m_valid stays 1 (normal case) so a target that toggles ready on valid&ready
//   returns to not-ready; m_ready ignored. Granted sN_ready=1, sN_data_rd=captured data (0 for writes).
//   Non-granted requester sees ready=0, data_rd=0. Next state IDLE.
//  Latency: request in IDLE -> m_valid next cycle; m_ready at cycle t -> sN_ready at t+1. Min 3 cycles/transaction.
//  Requester drops valid the cycle after its ready; valid still high in IDLE = new request.
//  Requester dropping valid in BUSY is illegal; arbiter completes the transaction anyway.
//  Watchdog clears on entry to BUSY; 32-bit-safe width = clog2(TIMEOUT_CYC)+1; no wrap possible.
//  Simultaneous m_ready and timeout in same cycle: m_ready wins, no error.
//  Reset mid-transaction: immediate return to reset values; in-flight transaction lost, no ready issued.
// STRUCTURE
//  Package io_bus_pkg: state enum (IDLE/BUSY/DRAIN), TIMEOUT_DATA default, IO address constants
//   (SPART 28'h8000000/1, DVI_START 28'h8000004, DVI_ON 28'h8000005, TICK 28'h8000006).
//  Sub-module io_rr_arb2: 2-way round-robin picker (req[1:0], last, grant); rest in top.
// TESTING
//  1 s0 read 28'h8000006, target ready 3 cycles after m_valid with 32'h00000123 -> s0_ready 1 cycle later, s0_data_rd=32'h123, s1_ready=0.
//  2 s0 and s1 valid same cycle after reset -> s0 granted first, s1 granted in the IDLE following s0's DRAIN; grant_id 0 then 1.
//  3 Both hold valid continuously for 4 transactions -> grants alternate 0,1,0,1; no starvation.
//  4 s1 write 28'h8000004 data 32'h0100000, target never ready, TIMEOUT_CYC=16 -> s1_ready after 16 BUSY cycles,
//    s1_data_rd=32'hDEADBEEF, timeout_err 1-cycle pulse, err_addr=28'h8000004, m_valid 0 in DRAIN.
//  5 m_ready asserted on exactly the timeout cycle -> normal completion, timeout_err stays 0.
//  6 rst asserted during BUSY -> next cycle m_valid=0, no sN_ready, state IDLE, next request grants s0.

Source files
------------

// File: rtl/io_bus_pkg.sv
// io_bus_pkg
//  Shared definitions for the IO bus arbiter slice: arbiter FSM state encoding,
//  the default read data returned when a target never answers, and the
//  memory-mapped IO register addresses that sit behind the shared port.
package io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Read data handed back to a requester whose transaction was forced to
  // complete because the target never raised ready.
  localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEADBEEF;

  // IO register map behind the shared port.
  localparam logic [27:0] ADDR_SPART_DATA = 28'h8000000;
  localparam logic [27:0] ADDR_SPART_STAT = 28'h8000001;
  localparam logic [27:0] ADDR_DVI_START  = 28'h8000004;
  localparam logic [27:0] ADDR_DVI_ON     = 28'h8000005;
  localparam logic [27:0] ADDR_TICK       = 28'h8000006;

endpackage

// File: rtl/io_rr_arb2.sv
// io_rr_arb2
//  Two-way round-robin picker. Purely combinational; the caller owns the
//  "last granted" state and decides when the pick is actually taken.
// Ports
//  req    in   2  request vector, bit N = requester N
//  last   in   1  requester granted most recently
//  grant  out  1  chosen requester (only meaningful when any=1)
//  any    out  1  at least one request present
module io_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       any
);

  always_comb begin
    any   = |req;
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      // Contention: hand the port to whoever did not have it last.
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
//  Shares the single IO memory-mapped port between the CPU D-cache IO port
//  (requester 0) and the debug/boot-loader master (requester 1). One
//  transaction at a time, round-robin on contention, with a watchdog that
//  forces completion when a target never answers so the CPU cannot hang.
//  Each transaction walks IDLE -> BUSY -> DRAIN -> IDLE.
// Ports
//  clk, rst                  clock, synchronous active-high reset
//  sN_valid/rw/addr/data_wr  request from requester N (held until sN_ready)
//  sN_data_rd, sN_ready      completion pulse and read data (0 when not ready)
//  m_valid/rw/addr/data_wr   request driven to the IO port (0 when idle)
//  m_data_rd, m_ready        response from the IO port
//  grant_id                  current or last granted requester
//  timeout_err               one-cycle pulse on a forced completion
//  err_addr                  address of the last timed-out transaction
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int                ADDR_W       = 28,
  parameter int                DATA_W       = 32,
  parameter int                TIMEOUT_CYC  = 1024,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = TIMEOUT_DATA_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  input  logic              s0_rw,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_data_wr,
  output logic [DATA_W-1:0] s0_data_rd,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic              s1_rw,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_data_wr,
  output logic [DATA_W-1:0] s1_data_rd,
  output logic              s1_ready,
  output logic              m_valid,
  output logic              m_rw,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data_wr,
  input  logic [DATA_W-1:0] m_data_rd,
  input  logic              m_ready,
  output logic              grant_id,
  output logic              timeout_err,
  output logic [ADDR_W-1:0] err_addr
);

  // One extra bit over what TIMEOUT_CYC-1 needs, so the compare value always
  // fits and the counter can never wrap before it is reached.
  localparam int              WD_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  state_t              state, state_n;
  logic                grant_q;
  logic                rr_last;
  logic [WD_W-1:0]     wdog;
  logic [DATA_W-1:0]   rd_data_q;
  logic                timeout_q;
  logic [ADDR_W-1:0]   err_addr_q;

  logic                pick;
  logic                any_req;
  logic                sel_rw;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data_wr;
  logic                wd_hit;
  logic                active;
  logic                done;

  io_rr_arb2 u_rr (
    .req   ({s1_valid, s0_valid}),
    .last  (rr_last),
    .grant (pick),
    .any   (any_req)
  );

  assign sel_rw      = grant_q ? s1_rw      : s0_rw;
  assign sel_addr    = grant_q ? s1_addr    : s0_addr;
  assign sel_data_wr = grant_q ? s1_data_wr : s0_data_wr;

  // A ready arriving on the last allowed cycle takes priority over the timeout.
  assign wd_hit = (state == BUSY) && !m_ready && (wdog == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = BUSY;
      BUSY:    if (m_ready || wd_hit) state_n = DRAIN;
      DRAIN:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // rr_last resets to 1 so the very first contention after reset goes to s0,
  // while the visible grant_id still resets to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q    <= 1'b0;
      rr_last    <= 1'b1;
      wdog       <= '0;
      rd_data_q  <= '0;
      timeout_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_q <= pick;
            rr_last <= pick;
            wdog    <= '0;
          end
        end
        BUSY: begin
          if (m_ready) begin
            rd_data_q <= sel_rw ? '0 : m_data_rd;
          end else if (wd_hit) begin
            rd_data_q  <= TIMEOUT_DATA;
            timeout_q  <= 1'b1;
            err_addr_q <= sel_addr;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // In DRAIN the request stays visible so a target that toggles ready on
  // valid&ready falls back to not-ready; after a timeout it is withdrawn.
  always_comb begin
    active      = (state != IDLE);
    done        = (state == DRAIN);
    m_valid     = (state == BUSY) || (done && !timeout_q);
    m_rw        = active & sel_rw;
    m_addr      = active ? sel_addr    : '0;
    m_data_wr   = active ? sel_data_wr : '0;
    s0_ready    = done & ~grant_q;
    s1_ready    = done &  grant_q;
    s0_data_rd  = s0_ready ? rd_data_q : '0;
    s1_data_rd  = s1_ready ? rd_data_q : '0;
    grant_id    = grant_q;
    timeout_err = timeout_q;
    err_addr    = err_addr_q;
  end

endmodule
